// File: rtl/uart_rx_if.sv
// Bus between the uart_rx receiver and its consumer: serial pin, bit timing, received byte.
// Optional macro UART_RX_FRAME_ERR_EN adds the frame_err status bit.
interface uart_rx_if;
  logic        RX;
  logic [12:0] baud_div;
  logic        clr_rdy;
  logic [7:0]  rx_data;
  logic        rdy;
`ifdef UART_RX_FRAME_ERR_EN
  logic        frame_err;

  modport master (output RX, baud_div, clr_rdy, input  rx_data, rdy, frame_err);
  modport slave  (input  RX, baud_div, clr_rdy, output rx_data, rdy, frame_err);
`else
  modport master (output RX, baud_div, clr_rdy, input  rx_data, rdy);
  modport slave  (input  RX, baud_div, clr_rdy, output rx_data, rdy);
`endif
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, runtime bit period (baud_div + 1 clk), midpoint sampling, sticky rdy.
// Optional macro UART_RX_FRAME_ERR_EN adds frame_err (inverted stop-bit sample).
module uart_rx (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t      state_q, state_d;
  logic        rx_m_q, rx_m_d;
  logic        rx_s_q, rx_s_d;
  logic        rx_s_d_q, rx_s_d_d;
  logic [1:0]  flush_q, flush_d;
  logic [12:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rdy_q, rdy_d;
  logic        frame_err_q, frame_err_d;
  logic        armed, start, sample;
  logic        unused_start_bit;

  // The synchronizer resets to idle-high, so its first few outputs after reset do
  // not reflect the pin; start detection waits until the chain has been flushed.
  assign armed  = (flush_q == 2'd3);
  assign start  = armed & rx_s_d_q & ~rx_s_q;
  assign sample = (state_q == RECV) && (baud_cnt_q == 13'd0);

  // The start bit always lands in shift_q[0] and carries no payload.
  assign unused_start_bit = shift_q[0];

  always_comb begin
    rx_m_d      = bus.RX;
    rx_s_d      = rx_m_q;
    rx_s_d_d    = rx_s_q;
    flush_d     = armed ? flush_q : flush_q + 2'd1;
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rdy_d       = rdy_q;
    frame_err_d = frame_err_q;

    if (bus.clr_rdy) rdy_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RECV;
          baud_cnt_d  = bus.baud_div >> 1;
          bit_cnt_d   = 4'd0;
          rdy_d       = 1'b0;
          frame_err_d = 1'b0;
        end
      end
      RECV: begin
        if (sample) begin
          shift_d    = {rx_s_q, shift_q[8:1]};
          baud_cnt_d = bus.baud_div;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0 && rx_s_q) begin
            state_d = IDLE;
          end else if (bit_cnt_q == 4'd9) begin
            // Stop sample: shift_q holds start..D7, D0 at bit 1.
            state_d     = IDLE;
            rdy_d       = 1'b1;
            rx_data_d   = shift_q[8:1];
            frame_err_d = ~rx_s_q;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 13'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_s_d_q    <= 1'b1;
      flush_q     <= 2'd0;
      state_q     <= IDLE;
      baud_cnt_q  <= 13'd0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 9'd0;
      rx_data_q   <= 8'h00;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_m_q      <= rx_m_d;
      rx_s_q      <= rx_s_d;
      rx_s_d_q    <= rx_s_d_d;
      flush_q     <= flush_d;
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rdy     = rdy_q;

`ifdef UART_RX_FRAME_ERR_EN
  assign bus.frame_err = frame_err_q;
`else
  logic unused_frame_err;
  assign unused_frame_err = frame_err_q;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver with a runtime-programmable bit period. It pairs with the team's UART transmitter on the same `baud_div` convention.
- Double-flops the asynchronous `RX` line, detects the start bit, and samples each bit at its midpoint.
- Assembles one byte and presents it with a sticky `rdy` flag until software or the consumer logic clears it.
- Sits between the board serial pin and the MiniLab SPART/command front end.

Parameters:
- None. Bit timing is runtime via `baud_div`.

Ports:
- `clk` — input, 1 — system clock, 50 MHz.
- `rst_n` — input, 1 — asynchronous active-low reset.
- `RX` — input, 1 — serial data in; asynchronous to `clk`; idles high.
- `baud_div` — input, 13 — bit period minus one, in clk cycles. Example: 433 gives 434 clk/bit, i.e. 115200 baud at 50 MHz.
- `clr_rdy` — input, 1 — pulse high to clear `rdy`.
- `rx_data` — output, 8 — last received byte; LSB was first on the wire.
- `rdy` — output, 1 — byte available; stays high until cleared.

Behaviour:
- **Reset:** `rst_n` is asynchronous, active-low; clock is `clk`.
  - Both synchronizer flops reset to 1.
  - `rdy` = 0, `rx_data` = 8'h00, state = IDLE.
  - Baud and bit counters reset to 0.
- **Synchronizer:** two flops on `RX` give `rx_s`. A third flop gives `rx_s_d` for falling-edge detection.
  - Start detect `start` = `rx_s_d & ~rx_s`.
  - Latency from an `RX` pin edge to `start` is 2–3 clk.
- **Bit period:** `Tb` = `baud_div` + 1 clk, identical to the transmitter.
  - `baud_div` must be held constant while a frame is in progress. It is sampled at each counter reload.
- **Baud counter:** 13-bit down-counter.
  - On `start` in IDLE, load `baud_div` >> 1 (half-period). This puts the first sample near the start-bit centre.
  - On each sample, reload `baud_div`.
  - Decrement while in RECV.
  - `sample` = RECV && `baud_cnt` == 0.
- **Shift register:** 9-bit, right shift, `rx_s` enters at bit 8 on `sample`. Its sample order is start, D0..D7, then stop.
- **Bit counter:** 4-bit.
  - Cleared on `start`.
  - Incremented on each `sample`.
- **State machine:**
  - IDLE:
    - `start` → RECV.
    - Load the half-period and clear the bit counter.
    - `rdy` is cleared (a new frame invalidates the old flag).
  - RECV, first sample (bit_cnt == 0):
    - If `rx_s` == 1, this is a false start (glitch shorter than Tb/2). Return to IDLE with no `rdy` and `rx_data` unchanged.
    - Otherwise continue.
  - RECV, 10th sample (bit_cnt == 9, the stop bit):
    - Go to IDLE and set `rdy`.
    - Load `rx_data` with the 8 data bits in the same clk edge as `rdy` rises.
    - The stop bit value is ignored; see the optional feature.
  - The next `start` is accepted on the clk after the return to IDLE. Back-to-back frames with no idle gap must be received.
- **`rdy` flag:**
  - Set on the stop sample.
  - Cleared by `clr_rdy` or by a new `start`.
  - Set has priority over `clr_rdy` in the same cycle.
- **Overrun:** if a new byte completes while `rdy` is still high, `rx_data` is overwritten. There is no overrun flag.
- **`rx_data` stability:** holds its value between stop samples and never shows partially shifted data.
- **Reset mid-frame:** aborts the frame immediately and applies the reset values above. If `RX` is still low after `rst_n` releases, no `start` fires until a new high→low edge.
- **Line held low (break):** receives as 8'h00 with `rdy` = 1, then waits in IDLE for a new falling edge.

Optional Feature:
- Macro `UART_RX_FRAME_ERR_EN`.
- **When defined:**
  - Adds output port `frame_err` (1 bit, reset 0).
  - On the stop sample, `frame_err` is set to `~rx_s` and keeps that value until the next stop sample.
  - `rdy` and `rx_data` behave identically whether or not a framing error occurs.
  - A new `start` clears `frame_err`, in the same way as `rdy`.
- **When undefined:** no port and no logic; the stop bit value is ignored.

Test Plan:
- **Basic receive:** `baud_div` = 433; drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 434 clk/bit → `rdy` rises ~9.5·434 ±3 clk after the start edge; `rx_data` = 8'hA5; `rdy` stays high until `clr_rdy` is pulsed, then reads 0.
- **Loopback with the team's UART transmitter:** `baud_div` = 20; send 0x00, 0xFF, 0x55, 0x80 back-to-back (`trmt` on each `tx_done`) → four `rdy` events; `rx_data` sequence is 00, FF, 55, 80; no byte lost.
- **False start:** `baud_div` = 433; low glitch of 100 clk on `RX` → no `rdy`, FSM back in IDLE, `rx_data` unchanged. A valid 0x3C frame immediately after is received correctly.
- **Flag priority:** assert `clr_rdy` in the exact cycle of the stop sample → `rdy` = 1 afterwards. Leave `rdy` high and receive 0x11 then 0x22 → `rx_data` = 22 and `rdy` = 1. A new start edge while `rdy` = 1 clears `rdy` 2–3 clk after the edge.
- **Reset mid-frame:** assert `rst_n` low after the 4th data bit of 0xC3 → `rdy` = 0, `rx_data` = 00. After release, the next 0x7E frame is received correctly.
- **Tolerance and frame error:**
  - Drive 0x96 at a bit period +3% and −3% from nominal (`baud_div` = 433) → received correctly.
  - With `UART_RX_FRAME_ERR_EN` defined, a stop bit driven low → `rdy` = 1, `rx_data` correct, `frame_err` = 1. The next good frame gives `frame_err` = 0.
